// File: rtl/vqueue_reader.sv
// Pops header + argument words from the command queue and presents whole commands on a valid/ready port.
// Latency: cmd_valid rises 2+2N cycles after the header pop; while cmd_ready is low the command is held and no pops occur.
module vqueue_reader #(
    parameter int MAX_ARGS   = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     q_empty,
    input  logic [DATA_WIDTH-1:0]    q_data,
    output logic                     q_rd_en,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic [7:0]               cmd_opcode,
    output logic [3:0]               cmd_argc,
    output logic [32*MAX_ARGS-1:0]   cmd_args,
    output logic                     err,
    input  logic                     err_clr,
    output logic                     busy
);

    typedef enum logic [2:0] {
        IDLE,
        HDR_WAIT,
        ARG_POP,
        ARG_WAIT,
        OUT
    } state_t;

    state_t     state;
    logic [3:0] idx;
    logic [3:0] hdr_argc;
    logic       hdr_bad;

    assign hdr_argc = q_data[3:0];
    assign hdr_bad  = hdr_argc > 4'(MAX_ARGS);

    // Gated by reset_n so no word is popped while the reader is held in reset.
    assign q_rd_en = reset_n && !q_empty && (state == IDLE || state == ARG_POP);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cmd_valid  <= 1'b0;
            cmd_opcode <= '0;
            cmd_argc   <= '0;
            cmd_args   <= '0;
            idx        <= '0;
            err        <= 1'b0;
        end else begin
            // A new oversize header in the same cycle as err_clr keeps err set.
            err <= (err && !err_clr) || (state == HDR_WAIT && hdr_bad);

            case (state)
                IDLE: begin
                    if (!q_empty) state <= HDR_WAIT;
                end
                HDR_WAIT: begin
                    cmd_opcode <= q_data[31:24];
                    cmd_argc   <= hdr_argc;
                    cmd_args   <= '0;
                    idx        <= '0;
                    if (hdr_bad) begin
                        state <= IDLE;
                    end else if (hdr_argc == 4'd0) begin
                        state     <= OUT;
                        cmd_valid <= 1'b1;
                    end else begin
                        state <= ARG_POP;
                    end
                end
                ARG_POP: begin
                    if (!q_empty) state <= ARG_WAIT;
                end
                ARG_WAIT: begin
                    for (int k = 0; k < MAX_ARGS; k++) begin
                        if (idx == 4'(k)) cmd_args[32*k +: 32] <= q_data[31:0];
                    end
                    if (idx == cmd_argc - 4'd1) begin
                        state     <= OUT;
                        cmd_valid <= 1'b1;
                    end else begin
                        idx   <= idx + 4'd1;
                        state <= ARG_POP;
                    end
                end
                OUT: begin
                    if (cmd_ready) begin
                        state     <= IDLE;
                        cmd_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vqueue_reader.sv
// Directed bench for vqueue_reader: a small queue model feeds words, a monitor logs pops and accepted commands.
module tb_vqueue_reader;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         q_empty;
    logic [31:0]  q_data;
    logic         q_rd_en;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [7:0]   cmd_opcode;
    logic [3:0]   cmd_argc;
    logic [127:0] cmd_args;
    logic         err;
    logic         err_clr;
    logic         busy;

    always #5 clk = ~clk;

    vqueue_reader #(.MAX_ARGS(4), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .q_empty    (q_empty),
        .q_data     (q_data),
        .q_rd_en    (q_rd_en),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_opcode (cmd_opcode),
        .cmd_argc   (cmd_argc),
        .cmd_args   (cmd_args),
        .err        (err),
        .err_clr    (err_clr),
        .busy       (busy)
    );

    // Queue model: registered read data, one cycle after the pop.
    logic [31:0] mem [0:255];
    int          rd = 0;
    int          wr = 0;
    assign q_empty = (rd == wr);

    always @(posedge clk) begin
        if (q_rd_en) begin
            q_data <= mem[rd[7:0]];
            rd     <= rd + 1;
        end
    end

    typedef struct {
        logic [7:0]   op;
        logic [3:0]   argc;
        logic [127:0] args;
        int           cyc;
    } cmd_t;

    int   cyc = 0;
    logic vld_d = 1'b0;
    int   pop_cyc[$];
    int   vld_cyc[$];
    cmd_t acc[$];

    always @(posedge clk) begin : monitor
        cmd_t c;
        if (q_rd_en) pop_cyc.push_back(cyc);
        if (cmd_valid && !vld_d) vld_cyc.push_back(cyc);
        if (cmd_valid && cmd_ready) begin
            c.op   = cmd_opcode;
            c.argc = cmd_argc;
            c.args = cmd_args;
            c.cyc  = cyc;
            acc.push_back(c);
        end
        vld_d <= cmd_valid;
        cyc   <= cyc + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int pop_at(input int i);
        return (i < pop_cyc.size()) ? pop_cyc[i] : -1000;
    endfunction

    function automatic int vld_at(input int i);
        return (i < vld_cyc.size()) ? vld_cyc[i] : -2000;
    endfunction

    function automatic cmd_t acc_at(input int i);
        cmd_t z;
        z.op = 8'hxx; z.argc = 4'hx; z.args = 'x; z.cyc = -3000;
        return (i < acc.size()) ? acc[i] : z;
    endfunction

    task automatic push(input logic [31:0] w);
        mem[wr[7:0]] = w;
        wr = wr + 1;
    endtask

    task automatic clear_logs();
        pop_cyc.delete();
        vld_cyc.delete();
        acc.delete();
    endtask

    task automatic wait_acc(input string tag, input int n, input int budget);
        int t = 0;
        while (acc.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk(tag, acc.size(), n);
    endtask

    initial begin
        int unstable;
        int t;
        cmd_t c;

        reset_n   = 1'b0;
        cmd_ready = 1'b0;
        err_clr   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", cmd_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_rden", q_rd_en, 0);
        chk("rst_op", cmd_opcode, 0);
        chk("rst_args", cmd_args, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // 1: zero-argument command
        cmd_ready = 1'b1;
        clear_logs();
        push(32'h1200_0000);
        #1 chk("t1_rden", q_rd_en, 1);
        wait_acc("t1_acc", 1, 40);
        @(negedge clk);
        chk("t1_idle", busy, 0);
        chk("t1_npop", pop_cyc.size(), 1);
        chk("t1_lat", vld_at(0) - pop_at(0), 2);
        c = acc_at(0);
        chk("t1_op", c.op, 8'h12);
        chk("t1_argc", c.argc, 0);
        chk("t1_args", c.args, 0);

        // 2: two arguments already queued
        clear_logs();
        push(32'h3400_0002);
        push(32'hAAAA_0001);
        push(32'hBBBB_0002);
        wait_acc("t2_acc", 1, 40);
        chk("t2_pop1", pop_at(1) - pop_at(0), 2);
        chk("t2_pop2", pop_at(2) - pop_at(0), 4);
        chk("t2_lat", vld_at(0) - pop_at(0), 6);
        c = acc_at(0);
        chk("t2_op", c.op, 8'h34);
        chk("t2_args", c.args, {64'h0, 32'hBBBB_0002, 32'hAAAA_0001});

        // 3: second argument arrives late
        clear_logs();
        push(32'h7700_0002);
        push(32'h1111_0001);
        repeat (12) @(negedge clk);
        chk("t3_stall_rden", q_rd_en, 0);
        chk("t3_stall_busy", busy, 1);
        chk("t3_stall_vld", cmd_valid, 0);
        chk("t3_stall_npop", pop_cyc.size(), 2);
        push(32'h2222_0002);
        wait_acc("t3_acc", 1, 40);
        chk("t3_npop", pop_cyc.size(), 3);
        chk("t3_lat", vld_at(0) - pop_at(2), 2);
        c = acc_at(0);
        chk("t3_args", c.args, {64'h0, 32'h2222_0002, 32'h1111_0001});

        // 4: oversize header dropped, error sticky and clearable
        clear_logs();
        push(32'h5500_0007);
        push(32'h6600_0000);
        wait_acc("t4_acc", 1, 40);
        @(negedge clk);
        chk("t4_err", err, 1);
        chk("t4_pop_gap", pop_at(1) - pop_at(0), 2);
        c = acc_at(0);
        chk("t4_op", c.op, 8'h66);
        chk("t4_nacc", acc.size(), 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("t4_clr", err, 0);
        push(32'h5500_0007);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("t4_set_wins", err, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("t4_clr2", err, 0);
        repeat (2) @(negedge clk);

        // 5: backpressure with three commands queued, last one at argc == MAX_ARGS
        clear_logs();
        cmd_ready = 1'b0;
        push(32'h8100_0001);
        push(32'h0000_00A1);
        push(32'h8200_0000);
        push(32'h8300_0004);
        push(32'hC000_0001);
        push(32'hC000_0002);
        push(32'hC000_0003);
        push(32'hC000_0004);
        t = 0;
        while (!cmd_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        unstable = 0;
        repeat (20) begin
            @(negedge clk);
            if (cmd_valid !== 1'b1 || cmd_opcode !== 8'h81 || cmd_argc !== 4'd1 ||
                cmd_args !== 128'hA1 || q_rd_en !== 1'b0) unstable++;
        end
        chk("t5_hold", unstable, 0);
        chk("t5_hold_npop", pop_cyc.size(), 2);
        cmd_ready = 1'b1;
        wait_acc("t5_acc", 3, 100);
        c = acc_at(0);
        chk("t5_op0", c.op, 8'h81);
        chk("t5_b2b", pop_at(2) - c.cyc, 1);
        c = acc_at(1);
        chk("t5_op1", c.op, 8'h82);
        chk("t5_args1", c.args, 0);
        c = acc_at(2);
        chk("t5_op2", c.op, 8'h83);
        chk("t5_argc2", c.argc, 4);
        chk("t5_args2", c.args, {32'hC000_0004, 32'hC000_0003, 32'hC000_0002, 32'hC000_0001});
        chk("t5_err", err, 0);

        // 6: reset in ARG_WAIT, next word is treated as a header
        clear_logs();
        push(32'h9300_0003);
        push(32'h0000_00C1);
        push(32'h0000_00C2);
        push(32'h0000_00C3);
        push(32'h9400_0000);
        t = 0;
        while (pop_cyc.size() < 2 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("t6_pre_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_vld", cmd_valid, 0);
        chk("t6_rst_rden", q_rd_en, 0);
        chk("t6_rst_argc", cmd_argc, 0);
        @(negedge clk);
        reset_n = 1'b1;
        acc.delete();
        wait_acc("t6_acc", 1, 60);
        c = acc_at(0);
        chk("t6_op", c.op, 8'h00);
        chk("t6_argc", c.argc, 2);
        chk("t6_args", c.args, {64'h0, 32'h9400_0000, 32'h0000_00C3});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
